// File: rtl/wash_sequencer_param.sv
// Washing-machine programme sequencer with configurable phase lengths, rinse repeats,
// pause / door-open hold, soap handshake and a remaining-time counter that freezes while held.
module wash_sequencer_param #(
  parameter int TW        = 8,
  parameter int RW        = 12,
  parameter int FILL_T    = 8,
  parameter int WASH_T    = 12,
  parameter int DRAIN_T   = 8,
  parameter int RINSE_T   = 9,
  parameter int SPIN_T    = 12,
  parameter int MAX_RINSE = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          power,
  input  logic          start,
  input  logic          pause,
  input  logic          door_closed,
  input  logic          soap_ok,
  input  logic [2:0]    program_sel,
  input  logic [1:0]    rinse_count,
  output logic          valve_cold,
  output logic          valve_hot,
  output logic          valve_out,
  output logic [1:0]    motor,
  output logic          soap_req,
  output logic          door_lock,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] remaining,
  output logic [3:0]    state_o
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, SOAP_WAIT = 4'd1, FILL = 4'd2, WASH = 4'd3, DRAIN = 4'd4,
    RINSE = 4'd5, RDRAIN = 4'd6, SPIN = 4'd7, PAUSED = 4'd8, DONE = 4'd9
  } state_e;

  localparam logic [TW-1:0] FILL_LD  = TW'(FILL_T - 1);
  localparam logic [TW-1:0] WASH_LD  = TW'(WASH_T - 1);
  localparam logic [TW-1:0] DRAIN_LD = TW'(DRAIN_T - 1);
  localparam logic [TW-1:0] RINSE_LD = TW'(RINSE_T - 1);
  localparam logic [TW-1:0] SPIN_LD  = TW'(SPIN_T - 1);
  localparam logic [RW-1:0] PAIR_W   = RW'(RINSE_T + DRAIN_T);
  localparam logic [RW-1:0] WASH_W   = RW'(FILL_T + WASH_T + DRAIN_T);
  localparam logic [RW-1:0] SPIN_W   = RW'(SPIN_T);
  localparam logic [1:0]    MAX_R    = MAX_RINSE[1:0];

  state_e        state_q, state_d, saved_q, saved_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] remaining_q, remaining_d;
  logic [1:0]    rinse_cnt_q, rinse_cnt_d, rinse_tgt_q, rinse_tgt_d;
  logic [2:0]    prog_q, prog_d;
  logic          valve_cold_q, valve_cold_d, valve_hot_q, valve_hot_d, valve_out_q, valve_out_d;
  logic [1:0]    motor_q, motor_d;
  logic          soap_req_q, soap_req_d, door_lock_q, door_lock_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic          timed, timer_end;
  logic [1:0]    r_eff;
  logic [2:0]    rinse_next;
  logic [RW-1:0] rinse_total;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the
    // case statements can leave it unassigned and infer a latch.
    state_d     = state_q;
    saved_d     = saved_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    rinse_cnt_d = rinse_cnt_q;
    rinse_tgt_d = rinse_tgt_q;
    prog_d      = prog_q;

    r_eff = (rinse_count == 2'd0) ? 2'd1 : rinse_count;
    if (r_eff > MAX_R) r_eff = MAX_R;
    rinse_total = RW'(r_eff) * PAIR_W;
    rinse_next  = {1'b0, rinse_cnt_q} + 3'd1;
    timed       = state_q inside {FILL, WASH, DRAIN, RINSE, RDRAIN, SPIN};
    timer_end   = (timer_q == '0);

    if (!power) begin
      state_d     = IDLE;
      saved_d     = IDLE;
      timer_d     = '0;
      remaining_d = '0;
      rinse_cnt_d = '0;
    end else if (timed && (pause || !door_closed)) begin
      // Hold wins over a coinciding phase end; the frozen timer resumes where it stopped.
      state_d = PAUSED;
      saved_d = state_q;
    end else begin
      if (timed) begin
        if (remaining_q != '0) remaining_d = remaining_q - RW'(1);
        if (!timer_end) timer_d = timer_q - TW'(1);
      end
      case (state_q)
        IDLE: begin
          if (start && door_closed && (program_sel <= 3'd4)) begin
            prog_d      = program_sel;
            rinse_tgt_d = r_eff;
            rinse_cnt_d = '0;
            if (program_sel == 3'd4) begin
              remaining_d = SPIN_W;
              state_d     = SPIN;
              timer_d     = SPIN_LD;
            end else if (program_sel == 3'd3) begin
              remaining_d = rinse_total + SPIN_W;
              state_d     = RINSE;
              timer_d     = RINSE_LD;
            end else begin
              remaining_d = WASH_W + rinse_total + SPIN_W;
              state_d     = soap_ok ? FILL : SOAP_WAIT;
              timer_d     = FILL_LD;
            end
          end
        end
        SOAP_WAIT: if (soap_ok) begin state_d = FILL; timer_d = FILL_LD; end
        FILL:      if (timer_end) begin state_d = WASH; timer_d = WASH_LD; end
        WASH:      if (timer_end) begin state_d = DRAIN; timer_d = DRAIN_LD; end
        DRAIN:     if (timer_end) begin state_d = RINSE; timer_d = RINSE_LD; end
        RINSE:     if (timer_end) begin state_d = RDRAIN; timer_d = DRAIN_LD; end
        RDRAIN: begin
          if (timer_end) begin
            rinse_cnt_d = rinse_next[1:0];
            if (rinse_next < {1'b0, rinse_tgt_q}) begin
              state_d = RINSE;
              timer_d = RINSE_LD;
            end else begin
              state_d = SPIN;
              timer_d = SPIN_LD;
            end
          end
        end
        SPIN:    if (timer_end) state_d = DONE;
        PAUSED:  if (!pause && door_closed) state_d = saved_q;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so they track state_q exactly.
  always_comb begin
    valve_cold_d = 1'b0;
    valve_hot_d  = 1'b0;
    valve_out_d  = 1'b0;
    motor_d      = 2'd0;
    soap_req_d   = 1'b0;
    door_lock_d  = 1'b0;
    done_d       = 1'b0;
    busy_d       = (state_d != IDLE);
    case (state_d)
      SOAP_WAIT: begin soap_req_d = 1'b1; door_lock_d = 1'b1; end
      FILL: begin
        door_lock_d  = 1'b1;
        valve_cold_d = (prog_d == 3'd0) || (prog_d == 3'd2);
        valve_hot_d  = (prog_d == 3'd1) || (prog_d == 3'd2);
      end
      WASH:          begin door_lock_d = 1'b1; motor_d = 2'd1; end
      DRAIN, RDRAIN: begin door_lock_d = 1'b1; valve_out_d = 1'b1; end
      RINSE:         begin door_lock_d = 1'b1; valve_cold_d = 1'b1; motor_d = 2'd1; end
      SPIN:          begin door_lock_d = 1'b1; valve_out_d = 1'b1; motor_d = 2'd2; end
      PAUSED:        door_lock_d = door_closed;
      DONE:          done_d = 1'b1;
      default:       ;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      saved_q      <= IDLE;
      timer_q      <= '0;
      remaining_q  <= '0;
      rinse_cnt_q  <= '0;
      rinse_tgt_q  <= '0;
      prog_q       <= '0;
      valve_cold_q <= 1'b0;
      valve_hot_q  <= 1'b0;
      valve_out_q  <= 1'b0;
      motor_q      <= 2'd0;
      soap_req_q   <= 1'b0;
      door_lock_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      saved_q      <= saved_d;
      timer_q      <= timer_d;
      remaining_q  <= remaining_d;
      rinse_cnt_q  <= rinse_cnt_d;
      rinse_tgt_q  <= rinse_tgt_d;
      prog_q       <= prog_d;
      valve_cold_q <= valve_cold_d;
      valve_hot_q  <= valve_hot_d;
      valve_out_q  <= valve_out_d;
      motor_q      <= motor_d;
      soap_req_q   <= soap_req_d;
      door_lock_q  <= door_lock_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign valve_cold = valve_cold_q;
  assign valve_hot  = valve_hot_q;
  assign valve_out  = valve_out_q;
  assign motor      = motor_q;
  assign soap_req   = soap_req_q;
  assign door_lock  = door_lock_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign remaining  = remaining_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_wash_sequencer_param.sv
// Directed bench for wash_sequencer_param: hand-computed state, output and remaining-time
// expectations at chosen cycles of each programme, hold and power/reset scenario.
module tb_wash_sequencer_param;

  logic        clk = 1'b0;
  logic        rst, power, start, pause, door_closed, soap_ok;
  logic [2:0]  program_sel;
  logic [1:0]  rinse_count;
  logic        valve_cold, valve_hot, valve_out, soap_req, door_lock, busy, done;
  logic [1:0]  motor;
  logic [11:0] remaining;
  logic [3:0]  state_o;
  logic [8:0]  out_vec;

  int total = 0;
  int bad   = 0;

  // {valve_cold, valve_hot, valve_out, motor, soap_req, door_lock, busy, done}
  localparam logic [8:0] O_IDLE    = 9'b000_00_0_0_0_0;
  localparam logic [8:0] O_SOAP    = 9'b000_00_1_1_1_0;
  localparam logic [8:0] O_FILL_C  = 9'b100_00_0_1_1_0;
  localparam logic [8:0] O_FILL_H  = 9'b010_00_0_1_1_0;
  localparam logic [8:0] O_WASH    = 9'b000_01_0_1_1_0;
  localparam logic [8:0] O_DRAIN   = 9'b001_00_0_1_1_0;
  localparam logic [8:0] O_RINSE   = 9'b100_01_0_1_1_0;
  localparam logic [8:0] O_SPIN    = 9'b001_10_0_1_1_0;
  localparam logic [8:0] O_PAUSE_L = 9'b000_00_0_1_1_0;
  localparam logic [8:0] O_PAUSE_U = 9'b000_00_0_0_1_0;
  localparam logic [8:0] O_DONE    = 9'b000_00_0_0_1_1;

  assign out_vec = {valve_cold, valve_hot, valve_out, motor, soap_req, door_lock, busy, done};

  wash_sequencer_param dut (
    .clk(clk), .rst(rst), .power(power), .start(start), .pause(pause),
    .door_closed(door_closed), .soap_ok(soap_ok), .program_sel(program_sel),
    .rinse_count(rinse_count), .valve_cold(valve_cold), .valve_hot(valve_hot),
    .valve_out(valve_out), .motor(motor), .soap_req(soap_req), .door_lock(door_lock),
    .busy(busy), .done(done), .remaining(remaining), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] st, input logic [8:0] outs, input int rem);
    check({tag, ".state"}, 32'(state_o), 32'(st));
    check({tag, ".outs"}, 32'(out_vec), 32'(outs));
    check({tag, ".rem"}, 32'(remaining), rem);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [2:0] prog, input logic [1:0] rc);
    program_sel = prog;
    rinse_count = rc;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; power = 1'b1; start = 1'b0; pause = 1'b0;
    door_closed = 1'b1; soap_ok = 1'b1; program_sel = 3'd0; rinse_count = 2'd1;
    #2 chk("reset", 4'd0, O_IDLE, 0);
    #6 rst = 1'b0;
    step(1);
    chk("idle_after_reset", 4'd0, O_IDLE, 0);

    // Nominal cold wash, single rinse: 8+12+8+9+8+12 = 57 cycles.
    kick(3'd0, 2'd1);
    chk("cold.fill0", 4'd2, O_FILL_C, 57);
    step(7);  chk("cold.fill7", 4'd2, O_FILL_C, 50);
    step(1);  chk("cold.wash", 4'd3, O_WASH, 49);
    step(12); chk("cold.drain", 4'd4, O_DRAIN, 37);
    step(8);  chk("cold.rinse", 4'd5, O_RINSE, 29);
    step(9);  chk("cold.rdrain", 4'd6, O_DRAIN, 20);
    step(8);  chk("cold.spin", 4'd7, O_SPIN, 12);
    step(11); chk("cold.spin_last", 4'd7, O_SPIN, 1);
    step(1);  chk("cold.done", 4'd9, O_DONE, 0);
    step(1);  chk("cold.idle", 4'd0, O_IDLE, 0);

    // Hot wash waiting for soap; remaining frozen while waiting.
    soap_ok = 1'b0;
    kick(3'd1, 2'd1);
    chk("soap.wait0", 4'd1, O_SOAP, 57);
    step(20); chk("soap.wait20", 4'd1, O_SOAP, 57);
    soap_ok = 1'b1;
    step(1);  chk("soap.fill", 4'd2, O_FILL_H, 57);
    step(56); chk("soap.spin_last", 4'd7, O_SPIN, 1);
    step(1);  chk("soap.done", 4'd9, O_DONE, 0);
    step(1);  chk("soap.idle", 4'd0, O_IDLE, 0);

    // Rinse+spin with three rinses: 3*17+12 = 63.
    kick(3'd3, 2'd3);
    chk("r3.rinse1", 4'd5, O_RINSE, 63);
    step(9);  chk("r3.rdrain1", 4'd6, O_DRAIN, 54);
    step(8);  chk("r3.rinse2", 4'd5, O_RINSE, 46);
    step(17); chk("r3.rinse3", 4'd5, O_RINSE, 29);
    step(9);  chk("r3.rdrain3", 4'd6, O_DRAIN, 20);
    step(8);  chk("r3.spin", 4'd7, O_SPIN, 12);
    step(12); chk("r3.done", 4'd9, O_DONE, 0);
    step(1);  chk("r3.idle", 4'd0, O_IDLE, 0);

    // Spin only.
    kick(3'd4, 2'd1);
    chk("spin.start", 4'd7, O_SPIN, 12);
    step(12); chk("spin.done", 4'd9, O_DONE, 0);
    step(1);  chk("spin.idle", 4'd0, O_IDLE, 0);

    // Rinse count 0 behaves as one rinse: 17+12 = 29.
    kick(3'd3, 2'd0);
    chk("r0.rinse", 4'd5, O_RINSE, 29);
    step(17); chk("r0.spin", 4'd7, O_SPIN, 12);
    step(12); chk("r0.done", 4'd9, O_DONE, 0);
    step(1);  chk("r0.idle", 4'd0, O_IDLE, 0);

    // Pause coinciding with the last spin cycle: pause wins, spin exits one cycle after resume.
    kick(3'd4, 2'd1);
    step(11); chk("edge.spin_last", 4'd7, O_SPIN, 1);
    pause = 1'b1;
    step(1);  chk("edge.paused", 4'd8, O_PAUSE_L, 1);
    pause = 1'b0;
    step(1);  chk("edge.resume", 4'd7, O_SPIN, 1);
    step(1);  chk("edge.done", 4'd9, O_DONE, 0);
    step(1);

    // Pause at wash cycle 5 for 10 cycles, then door opened during spin.
    kick(3'd0, 2'd1);
    chk("hold.fill", 4'd2, O_FILL_C, 57);
    step(8);  chk("hold.wash0", 4'd3, O_WASH, 49);
    step(5);  chk("hold.wash5", 4'd3, O_WASH, 44);
    pause = 1'b1;
    step(1);  chk("hold.paused", 4'd8, O_PAUSE_L, 44);
    step(9);  chk("hold.paused9", 4'd8, O_PAUSE_L, 44);
    pause = 1'b0;
    step(1);  chk("hold.resume", 4'd3, O_WASH, 44);
    step(6);  chk("hold.wash_last", 4'd3, O_WASH, 38);
    step(1);  chk("hold.drain", 4'd4, O_DRAIN, 37);
    step(25); chk("hold.spin", 4'd7, O_SPIN, 12);
    step(3);  chk("hold.spin3", 4'd7, O_SPIN, 9);
    door_closed = 1'b0;
    step(1);  chk("door.paused", 4'd8, O_PAUSE_U, 9);
    step(2);  chk("door.paused2", 4'd8, O_PAUSE_U, 9);
    door_closed = 1'b1;
    step(1);  chk("door.resume", 4'd7, O_SPIN, 9);
    step(9);  chk("door.done", 4'd9, O_DONE, 0);
    step(1);  chk("door.idle", 4'd0, O_IDLE, 0);

    // Power loss during rinse, then a fresh start reloads its own total.
    kick(3'd3, 2'd1);
    chk("pwr.rinse", 4'd5, O_RINSE, 29);
    step(3);  chk("pwr.rinse3", 4'd5, O_RINSE, 26);
    power = 1'b0;
    step(1);  chk("pwr.off", 4'd0, O_IDLE, 0);
    power = 1'b1;
    kick(3'd4, 2'd1);
    chk("pwr.restart", 4'd7, O_SPIN, 12);
    step(2);  chk("pwr.spin2", 4'd7, O_SPIN, 10);

    // Asynchronous reset between edges clears outputs without a clock.
    #3 rst = 1'b1;
    #1 chk("arst", 4'd0, O_IDLE, 0);
    #1 rst = 1'b0;
    step(1);  chk("arst.idle", 4'd0, O_IDLE, 0);

    // Ignored requests: invalid programme, door open, pause in IDLE.
    kick(3'd6, 2'd1);
    chk("inv.prog6", 4'd0, O_IDLE, 0);
    door_closed = 1'b0;
    kick(3'd0, 2'd1);
    chk("inv.door_open", 4'd0, O_IDLE, 0);
    door_closed = 1'b1;
    pause = 1'b1;
    step(1);  chk("inv.pause_idle", 4'd0, O_IDLE, 0);
    pause = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wash_sequencer_param.md
Name: wash_sequencer_param

Overview:
Parametrised washing-machine programme sequencer. It replaces the fixed-timing controller with the following features:
- configurable phase durations and rinse-repeat count
- pause/resume with frozen timers
- door-open safety pause
- a soap request/acknowledge wait
- a remaining-time counter that stops while paused

It sits between the front-panel inputs and the valve/motor drivers.

Parameters:
TW, 8, phase timer width in bits.
RW, 12, remaining-time counter width in bits.
FILL_T, 8, fill phase length in cycles (>=1).
WASH_T, 12, wash agitation length in cycles (>=1).
DRAIN_T, 8, drain length in cycles (>=1); used after the wash and after each rinse.
RINSE_T, 9, rinse length in cycles (>=1).
SPIN_T, 12, final spin length in cycles (>=1).
MAX_RINSE, 3, upper clamp for the requested rinse count.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
power  in  1  synchronous power enable; low forces IDLE on the next edge
start  in  1  start request, sampled in IDLE only
pause  in  1  level pause request
door_closed  in  1  door sensor
soap_ok  in  1  soap present / acknowledge
program  in  3  0 cold, 1 hot, 2 warm, 3 rinse+spin, 4 spin-only, 5-7 invalid
rinse_count  in  2  requested rinses; 0 is treated as 1; clamped to MAX_RINSE
valve_cold  out  1  cold inlet valve
valve_hot  out  1  hot inlet valve
valve_out  out  1  drain valve
motor  out  2  0 off, 1 agitate, 2 spin
soap_req  out  1  soap request indicator
door_lock  out  1  door lock
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at programme end
remaining  out  RW  remaining active cycles
state_o  out  4  current state code

Behaviour:
- States and codes:
  - 0 IDLE, 1 SOAP_WAIT, 2 FILL, 3 WASH, 4 DRAIN
  - 5 RINSE, 6 RDRAIN, 7 SPIN, 8 PAUSED, 9 DONE
- Outputs are Moore outputs, decoded from the state register.
- Reset values: state IDLE; every output 0; phase timer 0; remaining 0; saved state IDLE; rinse counter 0.
- Power has priority over all other transitions: power=0 in any state forces IDLE on the next edge and clears all counters.
- IDLE, on start & door_closed & power & a valid programme:
  - Latch the programme and the effective rinse count R.
  - Load remaining with the total (below).
  - Next state:
    - programme 0-2: FILL if soap_ok, else SOAP_WAIT
    - programme 3: RINSE
    - programme 4: SPIN
  - Programmes 5-7 are ignored; the block stays in IDLE.
- Total cycle count, zero-extended to RW:
  - programmes 0-2: FILL_T + WASH_T + DRAIN_T + R*(RINSE_T + DRAIN_T) + SPIN_T
  - programme 3: R*(RINSE_T + DRAIN_T) + SPIN_T
  - programme 4: SPIN_T
- Phase timer:
  - Loaded with duration-1 on entry to each timed phase (FILL, WASH, DRAIN, RINSE, RDRAIN, SPIN).
  - Decrements every active cycle.
  - The phase exits on the edge where the timer equals 0, so each phase lasts exactly its duration in cycles.
  - remaining decrements every active cycle and saturates at 0.
- Phase sequence:
  - FILL -> WASH -> DRAIN -> RINSE -> RDRAIN.
  - After RDRAIN, the rinse counter increments; the next state is RINSE if the counter < R, else SPIN.
  - SPIN -> DONE -> IDLE.
  - remaining is 0 on entry to DONE.
- SOAP_WAIT:
  - Outputs soap_req=1 and door_lock=1.
  - Timers and remaining are frozen.
  - soap_ok=1 -> FILL on the next edge.
- PAUSED:
  - Entry: pause=1 or door_closed=0 in any timed phase. The current state is saved; timers are frozen.
  - Exit: pause=0 & door_closed=1 -> return to the saved state, resuming the timer from its frozen value.
  - Outputs in PAUSED: all valves and motor 0; door_lock equals door_closed, so it releases only when the door is already open.
- Pause priority:
  - If pause and the phase-end condition coincide, pause wins; the phase resumes with a timer of 0 and exits one cycle after resume.
  - pause has no effect in IDLE, SOAP_WAIT or DONE.
- Per-state outputs (all others 0):
  - FILL: door_lock=1; inlet valves set by programme — 0: cold; 1: hot; 2: cold and hot.
  - WASH: door_lock=1, motor=1.
  - DRAIN and RDRAIN: door_lock=1, valve_out=1.
  - RINSE: door_lock=1, valve_cold=1, motor=1.
  - SPIN: door_lock=1, valve_out=1, motor=2.
  - DONE: done=1, door_lock=0.

Test Plan:
1. Nominal cold wash: program=0, rinse_count=1, soap_ok=1, start pulse in IDLE -> FILL with valve_cold=1 for 8 cycles; WASH 12; DRAIN 8; RINSE 9; RDRAIN 8; SPIN 12; done pulses exactly 57 cycles after FILL entry with remaining=0.
2. Soap wait: program=1 with soap_ok=0 -> SOAP_WAIT, soap_req=1, remaining held at 57 for 20 cycles; soap_ok raised -> FILL with valve_hot=1; total run time unchanged.
3. Multi-rinse spin-only variants:
   - program=3, rinse_count=3 -> three RINSE/RDRAIN pairs, total 63 cycles, then SPIN.
   - program=4 -> SPIN for 12 cycles, done.
   - rinse_count=0 -> one rinse.
4. Pause/door: pause asserted at WASH cycle 5 for 10 cycles -> PAUSED, outputs 0, remaining frozen; on release WASH resumes for 7 more cycles. door_closed=0 during SPIN -> PAUSED with door_lock=0; door closed -> SPIN resumes.
5. Power/reset mid-run:
   - power=0 during RINSE -> IDLE next edge with all outputs 0; a new start begins a fresh total.
   - async rst asserted between clock edges -> outputs clear immediately.
6. Invalid programme: program=6 with start -> stays IDLE, busy=0; start with door_closed=0 -> ignored.
